aes_inv_cipher_ctrl: RTL and testbench

//  Iterative AES decryption sequencer: one inverse round per clock over a single
//  128-bit state register, driving combinational InvShiftRows/InvSubBytes/

---
 rtl/aes_inv_cipher_ctrl_if.sv | 36 +++
 rtl/aes_inv_cipher_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_aes_inv_cipher_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_inv_cipher_ctrl_if.sv
// ---------------------------------------------------------------------------
// aes_inv_cipher_ctrl_if
// Bundle of the handshake and bus signals around the iterative AES decryption
// sequencer.
//   in_valid / in_ready / in_block     ciphertext input handshake (128-bit)
//   rk_idx / rk_data                   round-key index out, round key back
//                                      (combinational, same-cycle store)
//   out_valid / out_ready / out_block  plaintext output handshake (128-bit)
//   busy                               sequencer not idle
// Modports:
//   slave  - the sequencer (aes_inv_cipher_ctrl)
//   master - the environment (block source, key store, plaintext sink)
// ---------------------------------------------------------------------------
interface aes_inv_cipher_ctrl_if #(
  parameter int RK_IDX_W = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [127:0]        in_block;
  logic [RK_IDX_W-1:0] rk_idx;
  logic [127:0]        rk_data;
  logic                out_valid;
  logic                out_ready;
  logic [127:0]        out_block;
  logic                busy;

  modport slave (
    input  in_valid, in_block, rk_data, out_ready,
    output in_ready, rk_idx, out_valid, out_block, busy
  );

  modport master (
    output in_valid, in_block, rk_data, out_ready,
    input  in_ready, rk_idx, out_valid, out_block, busy
  );
endinterface

// File: rtl/aes_inv_cipher_ctrl.sv
// ---------------------------------------------------------------------------
// aes_inv_cipher_ctrl
// Iterative AES decryption sequencer. One inverse round per clock is applied
// to a single 128-bit state register; the round keys are read combinationally
// from an external store addressed by rk_idx. Byte i of a block sits in bits
// [8i+7:8i] and maps to row i%4, column i/4 of the AES state.
//
// Parameters:
//   NR        number of rounds (10/12/14 for AES-128/192/256)
//   RK_IDX_W  width of the round-key index
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   abort     (only with AES_DEC_ABORT_EN) drop the block in flight
//   bus       aes_inv_cipher_ctrl_if.slave: input/output handshakes,
//             round-key index/data, busy
//
// Optional build macro: AES_DEC_ABORT_EN adds the abort input. Without it a
// block in flight can only be flushed by rst.
//
// Sequence: IDLE (accept, whitening with key NR) -> ROUND (keys NR-1 .. 1)
// -> FINAL (key 0, no InvMixColumns) -> DONE (hold until out_ready) -> IDLE.
// out_valid rises exactly NR clocks after the accept edge.
// ---------------------------------------------------------------------------
module aes_inv_cipher_ctrl #(
  parameter int NR       = 10,
  parameter int RK_IDX_W = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef AES_DEC_ABORT_EN
  input  logic abort,
`endif
  aes_inv_cipher_ctrl_if.slave bus
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_inv_cipher_ctrl: NR must be 10, 12 or 14");
  end
  if ((1 << RK_IDX_W) <= NR) begin : g_bad_idx_w
    $error("aes_inv_cipher_ctrl: RK_IDX_W too narrow for NR");
  end

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [RK_IDX_W-1:0] RK_LAST   = RK_IDX_W'(NR);
  localparam logic [RK_IDX_W-1:0] RC_FIRST  = RK_IDX_W'(NR - 1);
  localparam logic [RK_IDX_W-1:0] RC_ONE    = RK_IDX_W'(1);

  // Inverse S-box, entry 0 in the top byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Entry b starts at bit 8*(255-b) = {~b, 3'b000}.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by a 4-bit constant (9, 11, 13, 14 for InvMixColumns).
  function automatic logic [7:0] gf_mul_k(input logic [7:0] x, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
           (k[1] ? x2 : 8'h00) ^ (k[0] ? x  : 8'h00);
  endfunction

  // Row r is rotated right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(r + 4*c) +: 8] = s[8*(r + 4*((c - r + 4) % 4)) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c      +: 8];
      a1 = s[32*c + 8  +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      o[32*c      +: 8] = gf_mul_k(a0, 4'd14) ^ gf_mul_k(a1, 4'd11) ^
                          gf_mul_k(a2, 4'd13) ^ gf_mul_k(a3, 4'd9);
      o[32*c + 8  +: 8] = gf_mul_k(a0, 4'd9)  ^ gf_mul_k(a1, 4'd14) ^
                          gf_mul_k(a2, 4'd11) ^ gf_mul_k(a3, 4'd13);
      o[32*c + 16 +: 8] = gf_mul_k(a0, 4'd13) ^ gf_mul_k(a1, 4'd9)  ^
                          gf_mul_k(a2, 4'd14) ^ gf_mul_k(a3, 4'd11);
      o[32*c + 24 +: 8] = gf_mul_k(a0, 4'd11) ^ gf_mul_k(a1, 4'd13) ^
                          gf_mul_k(a2, 4'd9)  ^ gf_mul_k(a3, 4'd14);
    end
    return o;
  endfunction

  logic [1:0]          fsm;
  logic [RK_IDX_W-1:0] rc;
  logic [127:0]        state;
  logic [127:0]        ark_c;
  logic [127:0]        imc_c;
  logic [RK_IDX_W-1:0] rk_idx_c;
  logic                abort_hit;

`ifdef AES_DEC_ABORT_EN
  // Abort only matters while a block is in flight; it outranks both handshakes.
  assign abort_hit = abort && (fsm != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // Round datapath: InvShiftRows -> InvSubBytes -> AddRoundKey (-> InvMixColumns)
  assign ark_c = inv_sub_bytes(inv_shift_rows(state)) ^ bus.rk_data;
  assign imc_c = inv_mix_columns(ark_c);

  always_comb begin
    rk_idx_c = '0;
    case (fsm)
      S_IDLE:  rk_idx_c = RK_LAST;
      S_ROUND: rk_idx_c = rc;
      default: rk_idx_c = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm   <= S_IDLE;
      rc    <= '0;
      state <= '0;
    end else if (abort_hit) begin
      fsm <= S_IDLE;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (bus.in_valid) begin
            state <= bus.in_block ^ bus.rk_data;
            rc    <= RC_FIRST;
            fsm   <= S_ROUND;
          end
        end
        S_ROUND: begin
          state <= imc_c;
          rc    <= rc - RC_ONE;
          if (rc == RC_ONE) begin
            fsm <= S_FINAL;
          end
        end
        S_FINAL: begin
          state <= ark_c;
          fsm   <= S_DONE;
        end
        default: begin
          if (bus.out_ready) begin
            fsm <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = (fsm == S_IDLE);
  assign bus.busy      = (fsm != S_IDLE);
  assign bus.out_valid = (fsm == S_DONE);
  assign bus.out_block = state;
  assign bus.rk_idx    = rk_idx_c;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_cipher_ctrl
// Directed bench for the iterative AES decryption sequencer. Round keys come
// from a key expansion done in the bench; extra ciphertexts are produced by a
// forward AES model in the bench (FIPS byte order, byte 0 first).
// ---------------------------------------------------------------------------
module tb_aes_inv_cipher_ctrl;

  localparam int NR_A = 10;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  logic [7:0]   sb [256];
  logic [127:0] rk_f [0:1][0:15];

  aes_inv_cipher_ctrl_if #(.RK_IDX_W(4)) bus ();

`ifdef AES_DEC_ABORT_EN
  logic abort;
  logic abort14;
  aes_inv_cipher_ctrl_if #(.RK_IDX_W(4)) bus14 ();

  aes_inv_cipher_ctrl #(.NR(NR_A), .RK_IDX_W(4)) dut (
    .clk(clk), .rst(rst), .abort(abort), .bus(bus)
  );
  aes_inv_cipher_ctrl #(.NR(14), .RK_IDX_W(4)) dut14 (
    .clk(clk), .rst(rst), .abort(abort14), .bus(bus14)
  );
  always_comb bus14.rk_data = rev(rk_f[1][bus14.rk_idx]);
`else
  aes_inv_cipher_ctrl #(.NR(NR_A), .RK_IDX_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  always_comb bus.rk_data = rev(rk_f[0][bus.rk_idx]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model helpers ----------------
  function automatic logic [127:0] rev(input logic [127:0] x);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = x[127-8*i -: 8];
    return o;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Forward S-box from the field inverse plus the affine map.
  task automatic build_sbox();
    logic [7:0] y, s;
    for (int x = 0; x < 256; x++) begin
      y = 8'h00;
      for (int c = 1; c < 256; c++)
        if (x != 0 && gmul(8'(x), 8'(c)) == 8'h01) y = 8'(c);
      s = y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
      sb[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic build_keys(input int set, input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4*(nr+1); i++) begin
      if (i < nk) w[i] = key[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
          rcon = xt(rcon);
        end else if (nk > 6 && i % nk == 4) begin
          t = subw(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++) rk_f[set][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input int set, input int nr);
    logic [127:0] s, o;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ rk_f[set][0];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[8*i +: 8] = sb[s[8*i +: 8]];
      o = s;
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          o[127-8*(q+4*c) -: 8] = s[127-8*(q+4*((c+q)%4)) -: 8];
      s = o;
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-8*(4*c)   -: 8];
          a1 = s[127-8*(4*c+1) -: 8];
          a2 = s[127-8*(4*c+2) -: 8];
          a3 = s[127-8*(4*c+3) -: 8];
          o[127-8*(4*c)   -: 8] = gmul(a0,8'h02) ^ gmul(a1,8'h03) ^ a2 ^ a3;
          o[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1,8'h02) ^ gmul(a2,8'h03) ^ a3;
          o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2,8'h02) ^ gmul(a3,8'h03);
          o[127-8*(4*c+3) -: 8] = gmul(a0,8'h03) ^ a1 ^ a2 ^ gmul(a3,8'h02);
        end
        s = o;
      end
      s = s ^ rk_f[set][r];
    end
    return s;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offer one block in IDLE; returns at the first negedge after the accept edge.
  task automatic send(input logic [127:0] ct_fips);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_block = rev(ct_fips);
    chk("in_ready_idle", bus.in_ready, 1'b1);
    chk("rk_idx_idle", bus.rk_idx, 4'd10);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic [127:0] pt_fips);
    int n;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, NR_A);
    chk({tag, "_pt"}, bus.out_block, rev(pt_fips));
  endtask

  logic [127:0] ct_c1, pt_c1, pt3, ct3, hold;
  logic [127:0] pt4 [4];
  logic [127:0] ct4 [4];
  int           acc_cyc [4];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int idx, oidx, cyc, n;
    bit acc_flag, seen;
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_block  = '0;
    bus.out_ready = 1'b1;
`ifdef AES_DEC_ABORT_EN
    abort = 1'b0;
    abort14 = 1'b0;
    bus14.in_valid  = 1'b0;
    bus14.in_block  = '0;
    bus14.out_ready = 1'b1;
`endif
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < 16; r++) rk_f[s][r] = '0;
    build_sbox();
    build_keys(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    build_keys(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    ct_c1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    pt_c1 = 128'h00112233445566778899aabbccddeeff;

    // Reset values
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_rk_idx", bus.rk_idx, 4'd10);
    chk("rst_out_block", bus.out_block, 128'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Tests 1/2: FIPS-197 C.1 with rk_idx trace and exact latency
    send(ct_c1);
    for (int j = 0; j < 10; j++) begin
      chk("t2_rk_idx", bus.rk_idx, (j < 9) ? 128'(9 - j) : 128'h0);
      chk("t2_in_ready", bus.in_ready, 1'b0);
      chk("t1_out_valid_early", bus.out_valid, 1'b0);
      @(negedge clk);
    end
    chk("t1_out_valid", bus.out_valid, 1'b1);
    chk("t2_rk_idx_done", bus.rk_idx, 4'd0);
    chk("t2_in_ready_done", bus.in_ready, 1'b0);
    chk("t1_pt", bus.out_block, rev(pt_c1));
    @(negedge clk);
    chk("t1_back_idle", bus.in_ready, 1'b1);
    chk("t1_busy_idle", bus.busy, 1'b0);
    chk("t1_out_valid_idle", bus.out_valid, 1'b0);
    chk("t1_block_kept", bus.out_block, rev(pt_c1));

    // Test 3: back-pressure in DONE
    pt3 = 128'h0123456789abcdeffedcba9876543210;
    ct3 = aes_enc(pt3, 0, 10);
    bus.out_ready = 1'b0;
    send(ct3);
    wait_out("t3", pt3);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("t3_hold_valid", bus.out_valid, 1'b1);
      chk("t3_hold_block", bus.out_block, rev(pt3));
      chk("t3_hold_in_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t3_release_idle", bus.in_ready, 1'b1);
    chk("t3_release_valid", bus.out_valid, 1'b0);
    chk("t3_release_block", bus.out_block, rev(pt3));

    // Test 4: back-to-back with in_valid held high
    pt4[0] = 128'h3243f6a8885a308d313198a2e0370734;
    pt4[1] = 128'hffffffffffffffffffffffffffffffff;
    pt4[2] = 128'h00000000000000000000000000000000;
    pt4[3] = 128'h80000000000000000000000000000001;
    for (int i = 0; i < 4; i++) begin
      ct4[i] = aes_enc(pt4[i], 0, 10);
      acc_cyc[i] = 0;
    end
    idx = 0; oidx = 0; cyc = 0; acc_flag = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_block = rev(ct4[0]);
    while (oidx < 4 && cyc < 100) begin
      if (acc_flag) begin
        acc_flag = 1'b0;
        idx++;
        if (idx < 4) bus.in_block = rev(ct4[idx]);
        else bus.in_valid = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("t4_pt", bus.out_block, rev(pt4[oidx]));
        oidx++;
      end
      if (bus.in_valid && bus.in_ready) begin
        acc_flag = 1'b1;
        acc_cyc[idx] = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("t4_count", oidx, 4);
    for (int i = 1; i < 4; i++) chk("t4_gap", acc_cyc[i] - acc_cyc[i-1], 12);

    // Test 5: asynchronous reset mid-operation
    @(negedge clk);
    send(ct_c1);
    n = 0;
    while (bus.rk_idx != 4'd5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reach_rc5", bus.rk_idx, 4'd5);
    #2 rst = 1'b1;
    #1;
    chk("t5_in_ready", bus.in_ready, 1'b1);
    chk("t5_busy", bus.busy, 1'b0);
    chk("t5_out_valid", bus.out_valid, 1'b0);
    chk("t5_rk_idx", bus.rk_idx, 4'd10);
    chk("t5_out_block", bus.out_block, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    send(ct_c1);
    wait_out("t5", pt_c1);
    @(negedge clk);

`ifdef AES_DEC_ABORT_EN
    // Test 6a: abort at rc=3 drops the block
    send(ct3);
    n = 0;
    while (bus.rk_idx != 4'd3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach_rc3", bus.rk_idx, 4'd3);
    hold = bus.out_block;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t6_abort_idle", bus.in_ready, 1'b1);
    chk("t6_abort_busy", bus.busy, 1'b0);
    chk("t6_abort_state", bus.out_block, hold);
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (bus.out_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("t6_no_output", seen, 1'b0);

    // Test 6b: NR=14 with FIPS-197 C.3
    bus14.in_valid = 1'b1;
    bus14.in_block = rev(128'h8ea2b7ca516745bfeafc49904b496089);
    chk("t6_14_idle_idx", bus14.rk_idx, 4'd14);
    @(negedge clk);
    bus14.in_valid = 1'b0;
    n = 0;
    while (!bus14.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t6_14_lat", n, 14);
    chk("t6_14_pt", bus14.out_block, rev(pt_c1));
    @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
